// File: rtl/tl_phase_scheduler.sv
// tl_phase_scheduler
// Demand-driven phase scheduler for a four-way intersection. Approaches with
// vehicle or pending-walk demand are served round-robin, with programmable
// green / yellow / all-red durations counted in one-second ticks.
// Optional emergency preemption is compiled in when TL_PREEMPT_EN is defined;
// without it the preempt inputs are accepted but ignored.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_ALLRED  | all lamps red, no walk; arbitration happens on exit
//   S_GREEN   | granted approach green, its crossing walk on
//   S_YELLOW  | granted approach yellow, walk still on
module tl_phase_scheduler #(
    parameter int GREEN_TICKS   = 4,
    parameter int YELLOW_TICKS  = 2,
    parameter int ALLRED_TICKS  = 1,
    parameter int PED_EXT_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] veh_req,
    input  logic [3:0] ped_req,
    input  logic       preempt,
    input  logic [1:0] preempt_dir,
    output logic [2:0] tl_1,
    output logic [2:0] tl_2,
    output logic [2:0] tl_3,
    output logic [2:0] tl_4,
    output logic       ped_1,
    output logic       ped_2,
    output logic       ped_3,
    output logic       ped_4,
    output logic [1:0] active_dir,
    output logic [3:0] ped_pend
);

    localparam int GREEN_EXT = GREEN_TICKS + PED_EXT_TICKS;
    localparam int MAX_GY    = (GREEN_EXT > YELLOW_TICKS) ? GREEN_EXT : YELLOW_TICKS;
    localparam int MAX_LEN   = (MAX_GY > ALLRED_TICKS) ? MAX_GY : ALLRED_TICKS;
    localparam int CNT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Terminal-count values: a phase of length N exits on the tick seen at cnt == N-1.
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] YL_LAST  = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] GR_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] GRX_LAST = CNT_W'(GREEN_EXT - 1);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] glast_q, glast_d;
    logic [1:0]       active_q, active_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0][2:0]  tl_q, tl_d;
    logic [3:0]       walk_q, walk_d;

    logic [3:0]       pend_eff;
    logic [3:0]       demand;
    logic [1:0]       grant;
    logic [1:0]       served;
    logic [CNT_W-1:0] last_cnt;
    logic             hold;
    logic             cut;

`ifndef TL_PREEMPT_EN
    logic unused_preempt;
    assign unused_preempt = ^{preempt, preempt_dir};
`endif

    // Walk requests merge into the pending set before arbitration looks at it,
    // so a request arriving on the deciding edge is already counted.
    always_comb begin
        pend_eff = pend_q | ped_req;
        demand   = '0;
        for (int k = 0; k < 4; k++) begin
            demand[k] = veh_req[k] | pend_eff[(k + 1) % 4];
        end
    end

    // Round-robin search starting after the last grant; idle intersection
    // keeps rotating so no approach is starved when demand returns.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        cand  = '0;
        found = 1'b0;
        grant = active_q + 2'd1;
        for (int i = 1; i <= 4; i++) begin
            cand = active_q + 2'(i);
            if (!found && demand[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
`ifdef TL_PREEMPT_EN
        if (preempt) begin
            grant = preempt_dir;
        end
`endif
        served = grant + 2'd1;
    end

    // Preemption: a conflicting green is cut on the next tick, the preempted
    // approach's own green is frozen until the request drops.
    always_comb begin
        hold = 1'b0;
        cut  = 1'b0;
`ifdef TL_PREEMPT_EN
        if (state_q == S_GREEN && preempt) begin
            if (preempt_dir == active_q) begin
                hold = 1'b1;
            end else begin
                cut = 1'b1;
            end
        end
`endif
    end

    // Terminal count for the current phase.
    always_comb begin
        case (state_q)
            S_GREEN:  last_cnt = glast_q;
            S_YELLOW: last_cnt = YL_LAST;
            default:  last_cnt = AR_LAST;
        endcase
    end

    // Next-state logic: phase sequencing, grant and walk-pending bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        pend_d   = pend_eff;
        glast_d  = glast_q;
        if (tick && !hold) begin
            if (cut || cnt_q == last_cnt) begin
                cnt_d = '0;
                case (state_q)
                    S_ALLRED: begin
                        state_d  = S_GREEN;
                        active_d = grant;
                        glast_d  = pend_eff[served] ? GRX_LAST : GR_LAST;
                        // Clearing the served walk overrides a request on the same edge.
                        pend_d[served] = 1'b0;
                    end
                    S_GREEN:  state_d = S_YELLOW;
                    S_YELLOW: state_d = S_ALLRED;
                    default:  state_d = S_ALLRED;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Lamp and walk decode from the next state so outputs leave a register.
    always_comb begin
        tl_d   = {4{3'b001}};
        walk_d = '0;
        if (state_d == S_GREEN) begin
            tl_d[active_d]          = 3'b100;
            walk_d[active_d + 2'd1] = 1'b1;
        end else if (state_d == S_YELLOW) begin
            tl_d[active_d]          = 3'b010;
            walk_d[active_d + 2'd1] = 1'b1;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_ALLRED;
            cnt_q    <= '0;
            glast_q  <= GR_LAST;
            active_q <= 2'd3;
            pend_q   <= '0;
            tl_q     <= {4{3'b001}};
            walk_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glast_q  <= glast_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            tl_q     <= tl_d;
            walk_q   <= walk_d;
        end
    end

    assign tl_1       = tl_q[0];
    assign tl_2       = tl_q[1];
    assign tl_3       = tl_q[2];
    assign tl_4       = tl_q[3];
    assign ped_1      = walk_q[0];
    assign ped_2      = walk_q[1];
    assign ped_3      = walk_q[2];
    assign ped_4      = walk_q[3];
    assign active_dir = active_q;
    assign ped_pend   = pend_q;

endmodule
